instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the control/ALU decode path: accepts symbolic instruction requests (class, ALU function, register numbers, immediate, jump target) over a valid/ready handshake.
- Encodes each request into a 32-bit MIPS word for the subset R-type ADD/SUB/AND/OR/SLT, LW, SW, BEQ, ADDI, J.
- Writes each word sequentially into instruction memory through a registered write port.
- Used by the test/boot loader to build programs for the pipelined core.

Parameters:
- ADDR_W, 6, instruction-memory word address width; capacity DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset; sampled on clk rising edge, active when 0
- clear  in  1  restart program: pointer and count to 0, sticky err cleared
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request this cycle
- in_kind  in  3  0=R-type, 1=LW, 2=SW, 3=BEQ, 4=ADDI, 5=J, 6..7 illegal
- in_alufn  in  3  R-type only: 010 add, 110 sub, 000 and, 001 or, 111 slt; others illegal
- in_rs, in_rt, in_rd  in  5 each  register numbers
- in_imm  in  16  immediate / branch offset, placed verbatim
- in_target  in  26  J word target, placed verbatim
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since reset/clear
- full  out  1  count == DEPTH
- err  out  1  sticky: an illegal request was dropped

Behaviour:
- Reset (reset==0 at edge): mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err=0, write pointer=0. in_ready=0 while reset is 0.
- in_ready = reset & ~clear & ~full (combinational).
- Accept = in_valid & in_ready. One request per cycle sustained; inputs are not stored beyond the accept edge.
- Latency 1: on the edge after accept, register mem_we=1, mem_addr=wptr, mem_wdata=encoding. Then wptr increments mod DEPTH and count increments.
- With no accept: mem_we=0 next cycle; mem_addr and mem_wdata hold their last values.
- Encodings, as {op[31:26], rs[25:21], rt[20:16], ...}:
  - R-type: op=000000, rd[15:11], shamt=00000, funct per alufn: add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - LW: op=100011, rs, rt, imm.
  - SW: op=101011, rs, rt, imm.
  - BEQ: op=000100, rs, rt, imm.
  - ADDI: op=001000, rs, rt, imm.
  - J: op=000010, target.
  - Fields not used by a class (e.g. in_rd for I-type, in_alufn for non-R) are ignored.
- Illegal request (kind 6/7, or R-type with unlisted alufn):
  - accepted (handshake completes), no write (mem_we=0), count and wptr unchanged;
  - err set next cycle and held until clear or reset.
- Full:
  - When the DEPTH-th word is written, count=DEPTH and full=1 in the same cycle that mem_we shows that write; in_ready drops.
  - wptr has wrapped to 0 but no further writes occur until clear.
- clear (synchronous, only when reset==1):
  - next edge sets wptr=0, count=0, full=0, err=0, mem_we=0;
  - in_ready is 0 during the clear cycle, so no accept;
  - a write already registered on the preceding edge is not affected. clear only suppresses the following cycle.
- reset mid-stream: all state returns to reset values; the pending strobe is dropped.
- reset takes priority over clear; clear takes priority over accept.

Optional Feature:
- Macro INSTR_ENCODER_CKSUM_EN.
- Defined: adds output port cksum [31:0].
  - Reset/clear to 0.
  - XOR-accumulated with every word actually written: updated on the same edge mem_we rises, so cksum reflects all writes including the current one.
  - Illegal requests do not affect cksum.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then R-type rs=1 rt=2 rd=3 alufn=010 -> next cycle mem_we=1, addr=0, wdata=0x00221820, count=1.
- Back-to-back LW rs=0 rt=2 imm=4; SW rs=3 rt=7 imm=8; BEQ rs=1 rt=2 imm=0xFFFF; ADDI rs=0 rt=5 imm=0xFFF9; J target=0x10 on consecutive cycles -> words 0x8C020004, 0xAC670008, 0x1022FFFF, 0x2005FFF9, 0x08000010 at addr 0..4 on consecutive cycles, count=5.
- kind=6, then R-type alufn=011 -> no mem_we, count unchanged, err=1 and held; next legal request writes at the unchanged address.
- ADDR_W=2: 4 legal writes -> full=1 with 4th strobe, in_ready=0, 5th valid held 3 cycles produces no write; clear -> count=0, full=0, next write at addr 0.
- reset=0 asserted the cycle after an accept -> no strobe, all outputs 0; clear and in_valid together -> no accept.
- With INSTR_ENCODER_CKSUM_EN: write 0x00221820 then 0x8C020004 -> cksum=0x8C201824; clear -> 0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic instruction requests into 32-bit MIPS words
// (ADD/SUB/AND/OR/SLT, LW, SW, BEQ, ADDI, J) and streams them into
// instruction memory through a registered write port.
// Optional: define INSTR_ENCODER_CKSUM_EN to add an XOR checksum output
// (cksum) accumulated over every word actually written.
module instr_encoder #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_alufn,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
`ifdef INSTR_ENCODER_CKSUM_EN
  ,
  output logic [31:0]       cksum
`endif
);

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_LW   = 3'd1,
    KIND_SW   = 3'd2,
    KIND_BEQ  = 3'd3,
    KIND_ADDI = 3'd4,
    KIND_J    = 3'd5
  } kind_e;

  typedef enum logic [2:0] {
    FN_AND = 3'b000,
    FN_OR  = 3'b001,
    FN_ADD = 3'b010,
    FN_SUB = 3'b110,
    FN_SLT = 3'b111
  } alufn_e;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  // count value at which the memory is full (DEPTH = 2**ADDR_W)
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic              we_q,    we_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] wptr_q,  wptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q,   err_d;
  logic [31:0]       cksum_q, cksum_d;

  logic        accept;
  logic        legal;
  logic [31:0] word;
  logic [5:0]  funct;

  assign full     = (count_q == FULL_CNT);
  assign in_ready = reset & ~clear & ~full;
  assign accept   = in_valid & in_ready;

  // Encode the current request and flag illegal kind/alufn combinations
  always_comb begin
    legal = 1'b0;
    word  = '0;
    funct = '0;
    case (in_alufn)
      FN_ADD:  funct = 6'b100000;
      FN_SUB:  funct = 6'b100010;
      FN_AND:  funct = 6'b100100;
      FN_OR:   funct = 6'b100101;
      FN_SLT:  funct = 6'b101010;
      default: funct = '0;
    endcase
    case (in_kind)
      KIND_R: begin
        legal = (funct != 6'b000000);
        word  = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b00000, funct};
      end
      KIND_LW: begin
        legal = 1'b1;
        word  = {OP_LW, in_rs, in_rt, in_imm};
      end
      KIND_SW: begin
        legal = 1'b1;
        word  = {OP_SW, in_rs, in_rt, in_imm};
      end
      KIND_BEQ: begin
        legal = 1'b1;
        word  = {OP_BEQ, in_rs, in_rt, in_imm};
      end
      KIND_ADDI: begin
        legal = 1'b1;
        word  = {OP_ADDI, in_rs, in_rt, in_imm};
      end
      KIND_J: begin
        legal = 1'b1;
        word  = {OP_J, in_target};
      end
      default: begin
        legal = 1'b0;
        word  = '0;
      end
    endcase
  end

  // Next-state: clear beats accept; addr/wdata hold when nothing is written
  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    err_d   = err_q;
    cksum_d = cksum_q;
    if (clear) begin
      wptr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
      cksum_d = '0;
    end else if (accept) begin
      if (legal) begin
        we_d    = 1'b1;
        addr_d  = wptr_q;
        wdata_d = word;
        wptr_d  = wptr_q + 1'b1;
        count_d = count_q + 1'b1;
        cksum_d = cksum_q ^ word;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      cksum_q <= '0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      cksum_q <= cksum_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign err       = err_q;

`ifdef INSTR_ENCODER_CKSUM_EN
  assign cksum = cksum_q;
`else
  logic unused_cksum;
  assign unused_cksum = ^cksum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected writes,
// a negedge monitor pops and compares whenever mem_we is seen.
module tb_instr_encoder;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_kind;
  logic [2:0]    in_alufn;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err;
`ifdef INSTR_ENCODER_CKSUM_EN
  logic [31:0]   cksum;
`endif

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_alufn  (in_alufn),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .in_target (in_target),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .full      (full),
    .err       (err)
`ifdef INSTR_ENCODER_CKSUM_EN
    ,
    .cksum     (cksum)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   word;
    logic [AW:0]   cnt;
    logic          full;
    logic [31:0]   ck;
  } exp_t;

  exp_t sb[$];

  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;
  logic [AW-1:0] exp_wptr  = '0;
  logic [AW:0]   exp_count = '0;
  logic [31:0]   exp_cksum = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {{(32-AW){1'b0}}, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("wr_addr",  32'(mem_addr),  32'(e.addr));
        chk("wr_data",  mem_wdata,      e.word);
        chk("wr_count", 32'(count),     32'(e.cnt));
        chk("wr_full",  32'(full),      32'(e.full));
`ifdef INSTR_ENCODER_CKSUM_EN
        chk("wr_cksum", cksum,          e.ck);
`endif
      end
    end
  end

  // Issue one request; caller is 1 time unit after a rising edge
  task automatic send(input logic [2:0] k, input logic [2:0] fn,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [15:0] imm, input logic [25:0] tg,
                      input logic [31:0] word, input bit legal);
    bit   acc;
    exp_t e;
    in_kind = k; in_alufn = fn; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_target = tg; in_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        acc = 1'b1;
        if (legal) begin
          exp_count = exp_count + 1'b1;
          exp_cksum = exp_cksum ^ word;
          e.addr = exp_wptr;
          e.word = word;
          e.cnt  = exp_count;
          e.full = (exp_count == (AW+1)'(DEPTH));
          e.ck   = exp_cksum;
          sb.push_back(e);
          exp_wptr = exp_wptr + 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_wptr = '0; exp_count = '0; exp_cksum = '0;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_kind = '0; in_alufn = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_imm = '0; in_target = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we",    32'(mem_we),   32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata,     32'd0);
    chk("rst_count", 32'(count),    32'd0);
    chk("rst_full",  32'(full),     32'd0);
    chk("rst_err",   32'(err),      32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // first R-type ADD; clear issued while its strobe is showing
    send(3'd0, 3'b010, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1820, 1'b1);
    do_clear();
    @(negedge clk);
    chk("clr_count", 32'(count), 32'd0);
    @(posedge clk); #1;

    // back-to-back I/J types at addr 0..4
    send(3'd1, 3'b000, 5'd0, 5'd2, 5'd0, 16'h0004, 26'h0, 32'h8C02_0004, 1'b1);
    send(3'd2, 3'b000, 5'd3, 5'd7, 5'd0, 16'h0008, 26'h0, 32'hAC67_0008, 1'b1);
    send(3'd3, 3'b000, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 32'h1022_FFFF, 1'b1);
    send(3'd4, 3'b000, 5'd0, 5'd5, 5'd0, 16'hFFF9, 26'h0, 32'h2005_FFF9, 1'b1);
    send(3'd5, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 32'h0800_0010, 1'b1);
    @(negedge clk);
    chk("b2b_count", 32'(count), 32'd5);
    @(posedge clk); #1;

    // illegal requests: no write, err sticky, pointer unchanged
    send(3'd6, 3'b010, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("ill_err1", 32'(err), 32'd1);
    @(posedge clk); #1;
    send(3'd0, 3'b011, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("ill_count", 32'(count), 32'd5);
    chk("ill_err2",  32'(err),   32'd1);
    @(posedge clk); #1;
    send(3'd4, 3'b000, 5'd0, 5'd1, 5'd9, 16'h0001, 26'h0, 32'h2001_0001, 1'b1);
    @(negedge clk);
    chk("ill_err_held", 32'(err), 32'd1);
    @(posedge clk); #1;

    // checksum pair, then clear
    do_clear();
    @(negedge clk);
    chk("clr_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    send(3'd0, 3'b010, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1820, 1'b1);
    send(3'd1, 3'b000, 5'd0, 5'd2, 5'd0, 16'h0004, 26'h0, 32'h8C02_0004, 1'b1);
    @(negedge clk);
`ifdef INSTR_ENCODER_CKSUM_EN
    chk("cksum_pair", cksum, 32'h8C20_1824);
`endif
    @(posedge clk); #1;
    do_clear();
    @(negedge clk);
`ifdef INSTR_ENCODER_CKSUM_EN
    chk("cksum_clr", cksum, 32'h0);
`endif
    chk("clr_count2", 32'(count), 32'd0);
    @(posedge clk); #1;

    // fill to DEPTH
    for (int i = 0; i < int'(DEPTH); i++)
      send(3'd4, 3'b000, 5'd0, 5'd1, 5'd0, 16'(i), 26'h0, 32'h2001_0000 | 32'(i), 1'b1);
    @(negedge clk);
    chk("full_flag",  32'(full),     32'd1);
    chk("full_count", 32'(count),    32'(DEPTH));
    chk("full_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_kind = 3'd4; in_imm = 16'h00AA; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("full_hold_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    do_clear();
    @(negedge clk);
    chk("unfull_flag", 32'(full), 32'd0);
    @(posedge clk); #1;
    send(3'd3, 3'b000, 5'd4, 5'd5, 5'd0, 16'h0010, 26'h0, 32'h1085_0010, 1'b1);
    send(3'd0, 3'b001, 5'd6, 5'd7, 5'd8, 16'h0, 26'h0, 32'h00C7_4025, 1'b1);
    send(3'd7, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0);

    // reset while a request is offered: no accept, everything zero
    reset = 1'b0;
    in_kind = 3'd4; in_rt = 5'd1; in_imm = 16'h0055; in_valid = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_we",    32'(mem_we),    32'd0);
    chk("rst_mid_addr",  32'(mem_addr),  32'd0);
    chk("rst_mid_wdata", mem_wdata,      32'd0);
    chk("rst_mid_count", 32'(count),     32'd0);
    chk("rst_mid_err",   32'(err),       32'd0);
`ifdef INSTR_ENCODER_CKSUM_EN
    chk("rst_mid_cksum", cksum,          32'd0);
`endif
    reset = 1'b1;
    in_valid = 1'b0;
    exp_wptr = '0; exp_count = '0; exp_cksum = '0;

    // clear together with valid: no accept
    send(3'd1, 3'b000, 5'd0, 5'd3, 5'd0, 16'h0020, 26'h0, 32'h8C03_0020, 1'b1);
    clear = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("clr_valid_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    exp_wptr = '0; exp_count = '0; exp_cksum = '0;
    @(negedge clk);
    chk("clr_valid_count", 32'(count), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
